// File: rtl/sparc_pkg.sv
// SPARC instruction field constants, decode types and the combinational field decoder
// shared by the IF/ID buffer and the decode stage.
package sparc_pkg;

  localparam logic [1:0] OP_FMT2 = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_MEM  = 2'b11;

  localparam logic [2:0] OP2_UNIMP = 3'b000;
  localparam logic [2:0] OP2_SETHI = 3'b100;

  typedef enum logic [1:0] {
    FMT_CALL = 2'd0,
    FMT_BR   = 2'd1,
    FMT_ALU  = 2'd2,
    FMT_MEM  = 2'd3
  } dec_fmt_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fetch_entry_t;

  typedef struct packed {
    logic [63:0] pc;
    dec_fmt_e    fmt;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        i;
    logic [63:0] imm;
    logic [63:0] disp;
    logic        illegal;
  } decoded_t;

  function automatic decoded_t decode_inst(input fetch_entry_t e);
    decoded_t d;
    d     = '0;
    d.pc  = e.pc;
    d.op2 = e.inst[24:22];
    d.op3 = e.inst[24:19];
    d.rd  = e.inst[29:25];
    d.rs1 = e.inst[18:14];
    d.i   = e.inst[13];
    d.rs2 = e.inst[4:0];
    case (e.inst[31:30])
      OP_CALL: begin
        d.fmt  = FMT_CALL;
        d.disp = {{32{e.inst[29]}}, e.inst[29:0], 2'b00};
      end
      OP_FMT2: begin
        d.fmt     = FMT_BR;
        d.disp    = {{40{e.inst[21]}}, e.inst[21:0], 2'b00};
        d.illegal = (e.inst[24:22] == OP2_UNIMP);
        // Only SETHI carries an immediate among the format-2 encodings.
        if (e.inst[24:22] == OP2_SETHI) begin
          d.imm = {32'h0000_0000, e.inst[21:0], 10'h000};
        end else begin
          d.imm = 64'h0;
        end
      end
      OP_ALU: begin
        d.fmt = FMT_ALU;
        d.imm = {{51{e.inst[12]}}, e.inst[12:0]};
      end
      OP_MEM: begin
        d.fmt = FMT_MEM;
        d.imm = {{51{e.inst[12]}}, e.inst[12:0]};
      end
      default: begin
        d.fmt = FMT_CALL;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// IF/ID instruction buffer: power-of-two circular FIFO with synchronous clear
// and asynchronous active-low reset.
module decode_fifo
  import sparc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;

  // Storage write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= '0;
      end
    end else if (push && !clear) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointer and occupancy bookkeeping; clear wins over push/pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/instruction_decode.sv
// SPARC decode stage: captures one instruction per fetch handshake into the IF/ID
// buffer, decodes the buffer head and presents it through a valid/ready output register.
module instruction_decode
  import sparc_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_write,
  input  logic [63:0] inst,
  input  logic [63:0] if_pc,
  output logic        id_read,
  output logic        id_stall,
  output logic [63:0] target,
  input  logic        flush,
  input  logic [63:0] flush_pc,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [63:0] dec_pc,
  output logic [1:0]  dec_fmt,
  output logic [2:0]  dec_op2,
  output logic [5:0]  dec_op3,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic        dec_i,
  output logic [63:0] dec_imm,
  output logic [63:0] dec_disp,
  output logic        dec_illegal
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          if_write_q;
  logic          armed_r;
  logic [63:0]   target_r;
  logic          dec_valid_r;
  decoded_t      dec_r;
  logic          capture_s;
  logic          pop_s;
  logic [CW-1:0] count_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_data_s;
  logic          unused_s;

  assign unused_s    = ^inst[63:32];
  assign id_read     = (count_s < CW'(FIFO_DEPTH));
  assign id_stall    = ~id_read;
  // armed_r blocks a capture when if_write is already high as reset releases.
  assign capture_s   = if_write & ~if_write_q & armed_r & id_read & ~flush;
  assign pop_s       = (count_s != CW'(0)) & (~dec_valid_r | dec_ready) & ~flush;
  assign push_data_s = '{inst: inst[31:0], pc: if_pc};

  decode_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (capture_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s)
  );

  // Fetch handshake edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_write_q <= 1'b0;
      armed_r    <= 1'b0;
    end else begin
      if_write_q <= if_write;
      armed_r    <= armed_r | ~if_write;
    end
  end

  // Next fetch PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_r <= 64'h0;
    end else if (flush) begin
      target_r <= flush_pc;
    end else if (capture_s) begin
      target_r <= if_pc + 64'd4;
    end else begin
      target_r <= target_r;
    end
  end

  // Decoded output register with valid/ready hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_valid_r <= 1'b0;
      dec_r       <= '0;
    end else if (flush) begin
      dec_valid_r <= 1'b0;
      dec_r       <= dec_r;
    end else if (pop_s) begin
      dec_valid_r <= 1'b1;
      dec_r       <= decode_inst(head_s);
    end else if (dec_ready) begin
      dec_valid_r <= 1'b0;
      dec_r       <= dec_r;
    end else begin
      dec_valid_r <= dec_valid_r;
      dec_r       <= dec_r;
    end
  end

  assign target      = target_r;
  assign dec_valid   = dec_valid_r;
  assign dec_pc      = dec_r.pc;
  assign dec_fmt     = dec_r.fmt;
  assign dec_op2     = dec_r.op2;
  assign dec_op3     = dec_r.op3;
  assign dec_rd      = dec_r.rd;
  assign dec_rs1     = dec_r.rs1;
  assign dec_rs2     = dec_r.rs2;
  assign dec_i       = dec_r.i;
  assign dec_imm     = dec_r.imm;
  assign dec_disp    = dec_r.disp;
  assign dec_illegal = dec_r.illegal;

endmodule
